// File: rtl/bch_encoder_core.sv
// Systematic serial BCH encoder: message bits are placed at the top of the codeword while an
// r-bit LFSR divides by g(x); the remainder fills the low r bits as parity.
module bch_encoder_core #(
    parameter int unsigned N_MAX = 1023,
    parameter int unsigned T_MAX = 4,
    parameter int unsigned M_MAX = 10,
    localparam int unsigned R_MAX = M_MAX * T_MAX,
    localparam int unsigned NW = $clog2(N_MAX + 1),
    localparam int unsigned RW = $clog2(R_MAX + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [NW-1:0]    n,
    input  logic [RW-1:0]    r,
    input  logic [R_MAX-1:0] gen_poly,
    input  logic             msg_valid,
    input  logic             msg_bit,
    output logic             msg_ready,
    output logic             busy,
    output logic             done,
    output logic             cfg_err,
    output logic [N_MAX-1:0] code_bits
);

    typedef enum logic [1:0] {StIdle, StMsg, StPar, StDone} state_e;

    state_e           state;
    logic [NW-1:0]    n_q;
    logic [RW-1:0]    r_q;
    logic [R_MAX-1:0] g_q;
    logic [R_MAX-1:0] lfsr_q;
    logic [NW-1:0]    cnt_q;

    logic [R_MAX-1:0] start_mask;
    logic [R_MAX-1:0] r_mask;
    logic [R_MAX-1:0] lfsr_nxt;
    logic [R_MAX-1:0] par_bits;
    logic [NW-1:0]    wr_idx;
    logic [NW-1:0]    k_last;
    logic             cfg_bad;
    logic             fb;

    function automatic logic [R_MAX-1:0] low_mask(input logic [RW-1:0] w);
        return (R_MAX'(1) << w) - R_MAX'(1);
    endfunction

    always_comb begin
        start_mask = low_mask(r);
        r_mask     = low_mask(r_q);
        cfg_bad    = (r == '0) || (r > RW'(R_MAX)) || (NW'(r) >= n);
        // The top LFSR bit is isolated by mask ^ (mask >> 1), avoiding a variable index.
        fb         = msg_bit ^ (|(lfsr_q & (r_mask ^ (r_mask >> 1))));
        lfsr_nxt   = ((lfsr_q << 1) & r_mask) ^ (fb ? g_q : '0);
        par_bits   = (code_bits[R_MAX-1:0] & ~r_mask) | lfsr_q;
        wr_idx     = n_q - NW'(1) - cnt_q;
        k_last     = n_q - NW'(r_q) - NW'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= StIdle;
            n_q       <= '0;
            r_q       <= '0;
            g_q       <= '0;
            lfsr_q    <= '0;
            cnt_q     <= '0;
            msg_ready <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            cfg_err   <= 1'b0;
            code_bits <= '0;
        end else begin
            done <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (start) begin
                        n_q       <= n;
                        r_q       <= r;
                        g_q       <= gen_poly & start_mask;
                        lfsr_q    <= '0;
                        cnt_q     <= '0;
                        code_bits <= '0;
                        busy      <= 1'b1;
                        if (cfg_bad) begin
                            cfg_err <= 1'b1;
                            done    <= 1'b1;
                            state   <= StDone;
                        end else begin
                            cfg_err   <= 1'b0;
                            msg_ready <= 1'b1;
                            state     <= StMsg;
                        end
                    end
                end
                StMsg: begin
                    if (msg_valid && msg_ready) begin
                        code_bits[wr_idx] <= msg_bit;
                        lfsr_q            <= lfsr_nxt;
                        cnt_q             <= cnt_q + NW'(1);
                        if (cnt_q == k_last) begin
                            msg_ready <= 1'b0;
                            state     <= StPar;
                        end
                    end
                end
                StPar: begin
                    code_bits[R_MAX-1:0] <= par_bits;
                    done                 <= 1'b1;
                    state                <= StDone;
                end
                StDone: begin
                    busy  <= 1'b0;
                    state <= StIdle;
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule
